// File: rtl/flexka_command_sequencer_if.sv
// Host command/data port of the FlexKA sequencer: one beat per cycle,
// transferred when cmd_valid && cmd_ready.
interface flexka_command_sequencer_if #(
  parameter int FSIZE         = 64,
  parameter int COMMAND_WIDTH = 8
);
  logic                     cmd_valid;
  logic [COMMAND_WIDTH-1:0] cmd_command;
  logic [FSIZE-1:0]         cmd_data0;
  logic [FSIZE-1:0]         cmd_data1;
  logic                     cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_command,
    output cmd_data0,
    output cmd_data1,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_command,
    input  cmd_data0,
    input  cmd_data1,
    output cmd_ready
  );
endinterface

// File: rtl/flexka_command_sequencer.sv
// Front-end controller for the FlexKA Karatsuba core: decodes host beats, loads
// Mem_A/Mem_B, latches sizes/output address and runs one multiplication at a time.
module flexka_command_sequencer #(
  parameter int          FSIZE          = 64,
  parameter int          COMMAND_WIDTH  = 8,
  parameter logic [31:0] IN_BUFFER_SIZE = 32'h2800
) (
  input  logic                     clk,
  input  logic                     rst,
  flexka_command_sequencer_if.slave cmd_if,
  output logic [31:0]              mem_a_waddr,
  output logic [FSIZE-1:0]         mem_a_wdata,
  output logic                     mem_a_wren,
  output logic [31:0]              mem_b_waddr,
  output logic [FSIZE-1:0]         mem_b_wdata,
  output logic                     mem_b_wren,
  output logic [31:0]              size_a,
  output logic [31:0]              size_b,
  output logic [31:0]              out_addr,
  output logic                     core_start,
  output logic                     core_soft_reset,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     done,
  output logic                     err_overflow,
  output logic                     err_size,
  output logic                     err_opcode
);

  localparam logic [COMMAND_WIDTH-1:0] OP_RESET     = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] OP_SIZE_A    = COMMAND_WIDTH'(2);
  localparam logic [COMMAND_WIDTH-1:0] OP_SIZE_B    = COMMAND_WIDTH'(3);
  localparam logic [COMMAND_WIDTH-1:0] OP_DATA_A    = COMMAND_WIDTH'(4);
  localparam logic [COMMAND_WIDTH-1:0] OP_DATA_B    = COMMAND_WIDTH'(5);
  localparam logic [COMMAND_WIDTH-1:0] OP_KARATSUBA = COMMAND_WIDTH'(6);
  localparam logic [COMMAND_WIDTH-1:0] OP_OUTADDR   = COMMAND_WIDTH'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_ptr_a;
  logic [31:0]        r_ptr_b;
  logic [31:0]        r_size_a;
  logic [31:0]        r_size_b;
  logic [31:0]        r_out_addr;
  logic [31:0]        r_mem_a_waddr;
  logic [FSIZE-1:0]   r_mem_a_wdata;
  logic               r_mem_a_wren;
  logic [31:0]        r_mem_b_waddr;
  logic [FSIZE-1:0]   r_mem_b_wdata;
  logic               r_mem_b_wren;
  logic               r_core_start;
  logic               r_core_soft_reset;
  logic               r_done;
  logic               r_err_overflow;
  logic               r_err_size;
  logic               r_err_opcode;

  logic               w_accept;
  logic [31:0]        w_data0_lo;
  logic               w_unused_data1;

  // Beats are only consumed in IDLE, so nothing is lost while a product is in flight.
  assign w_accept         = cmd_if.cmd_valid && (r_state == S_IDLE);
  assign w_data0_lo       = cmd_if.cmd_data0[31:0];
  assign w_unused_data1   = ^cmd_if.cmd_data1;
  assign cmd_if.cmd_ready = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_ptr_a           <= 32'd0;
      r_ptr_b           <= 32'd0;
      r_size_a          <= 32'd0;
      r_size_b          <= 32'd0;
      r_out_addr        <= 32'd0;
      r_mem_a_waddr     <= 32'd0;
      r_mem_a_wdata     <= '0;
      r_mem_a_wren      <= 1'b0;
      r_mem_b_waddr     <= 32'd0;
      r_mem_b_wdata     <= '0;
      r_mem_b_wren      <= 1'b0;
      r_core_start      <= 1'b0;
      r_core_soft_reset <= 1'b0;
      r_done            <= 1'b0;
      r_err_overflow    <= 1'b0;
      r_err_size        <= 1'b0;
      r_err_opcode      <= 1'b0;
    end else begin
      r_mem_a_wren      <= 1'b0;
      r_mem_b_wren      <= 1'b0;
      r_core_start      <= 1'b0;
      r_core_soft_reset <= 1'b0;
      r_done            <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_if.cmd_command)
              OP_RESET: begin
                r_ptr_a           <= 32'd0;
                r_ptr_b           <= 32'd0;
                r_size_a          <= 32'd0;
                r_size_b          <= 32'd0;
                r_out_addr        <= 32'd0;
                r_err_overflow    <= 1'b0;
                r_err_size        <= 1'b0;
                r_err_opcode      <= 1'b0;
                r_core_soft_reset <= 1'b1;
              end
              OP_SIZE_A: begin
                r_size_a <= w_data0_lo;
                r_ptr_a  <= 32'd0;
              end
              OP_SIZE_B: begin
                r_size_b <= w_data0_lo;
                r_ptr_b  <= 32'd0;
              end
              // A full buffer saturates the pointer and flags the dropped beat.
              OP_DATA_A: begin
                if (r_ptr_a < IN_BUFFER_SIZE) begin
                  r_mem_a_wren  <= 1'b1;
                  r_mem_a_waddr <= r_ptr_a;
                  r_mem_a_wdata <= cmd_if.cmd_data0;
                  r_ptr_a       <= r_ptr_a + 32'd1;
                end else begin
                  r_err_overflow <= 1'b1;
                end
              end
              OP_DATA_B: begin
                if (r_ptr_b < IN_BUFFER_SIZE) begin
                  r_mem_b_wren  <= 1'b1;
                  r_mem_b_waddr <= r_ptr_b;
                  r_mem_b_wdata <= cmd_if.cmd_data0;
                  r_ptr_b       <= r_ptr_b + 32'd1;
                end else begin
                  r_err_overflow <= 1'b1;
                end
              end
              OP_OUTADDR: begin
                r_out_addr <= w_data0_lo;
              end
              OP_KARATSUBA: begin
                if ((r_size_a == 32'd0) || (r_size_b == 32'd0)) begin
                  r_err_size <= 1'b1;
                end else begin
                  r_state      <= S_START;
                  r_core_start <= 1'b1;
                end
              end
              default: begin
                r_err_opcode <= 1'b1;
              end
            endcase
          end
        end
        S_START: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_ptr_a <= 32'd0;
          r_ptr_b <= 32'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_a_waddr     = r_mem_a_waddr;
  assign mem_a_wdata     = r_mem_a_wdata;
  assign mem_a_wren      = r_mem_a_wren;
  assign mem_b_waddr     = r_mem_b_waddr;
  assign mem_b_wdata     = r_mem_b_wdata;
  assign mem_b_wren      = r_mem_b_wren;
  assign size_a          = r_size_a;
  assign size_b          = r_size_b;
  assign out_addr        = r_out_addr;
  assign core_start      = r_core_start;
  assign core_soft_reset = r_core_soft_reset;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign err_overflow    = r_err_overflow;
  assign err_size        = r_err_size;
  assign err_opcode      = r_err_opcode;

endmodule

// File: tb/tb_flexka_command_sequencer.sv
// Directed bench for flexka_command_sequencer: linear stimulus, immediate-assertion checks.
module tb_flexka_command_sequencer;

  localparam int FSIZE = 64;
  localparam int CW    = 8;

  logic              clk;
  logic              rst;
  logic [31:0]       mem_a_waddr;
  logic [FSIZE-1:0]  mem_a_wdata;
  logic              mem_a_wren;
  logic [31:0]       mem_b_waddr;
  logic [FSIZE-1:0]  mem_b_wdata;
  logic              mem_b_wren;
  logic [31:0]       size_a;
  logic [31:0]       size_b;
  logic [31:0]       out_addr;
  logic              core_start;
  logic              core_soft_reset;
  logic              core_done;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic              err_size;
  logic              err_opcode;

  int n_tests;
  int n_fail;

  flexka_command_sequencer_if #(.FSIZE(FSIZE), .COMMAND_WIDTH(CW)) cmd_if ();

  flexka_command_sequencer #(
    .FSIZE(FSIZE),
    .COMMAND_WIDTH(CW),
    .IN_BUFFER_SIZE(32'h2800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_if(cmd_if),
    .mem_a_waddr(mem_a_waddr),
    .mem_a_wdata(mem_a_wdata),
    .mem_a_wren(mem_a_wren),
    .mem_b_waddr(mem_b_waddr),
    .mem_b_wdata(mem_b_wdata),
    .mem_b_wren(mem_b_wren),
    .size_a(size_a),
    .size_b(size_b),
    .out_addr(out_addr),
    .core_start(core_start),
    .core_soft_reset(core_soft_reset),
    .core_done(core_done),
    .busy(busy),
    .done(done),
    .err_overflow(err_overflow),
    .err_size(err_size),
    .err_opcode(err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle; on return the registered effects are visible.
  task automatic beat(input logic [7:0] cmd, input logic [63:0] d0);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_command = cmd;
    cmd_if.cmd_data0   = d0;
    tick();
    cmd_if.cmd_valid   = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst                = 1'b1;
    core_done          = 1'b0;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_command = '0;
    cmd_if.cmd_data0   = '0;
    cmd_if.cmd_data1   = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_size_a", size_a, 0);
    check("rst_errs", {err_overflow, err_size, err_opcode}, 0);
    check("rst_pulses", {mem_a_wren, mem_b_wren, core_start, done, core_soft_reset}, 0);
    $display("[TB] reset checked");

    // Operand load: SIZE_A=4, DATA_A x4 back-to-back
    beat(8'd2, 64'd4);
    check("size_a_4", size_a, 4);
    for (int i = 0; i < 4; i++) begin
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_command = 8'd4;
      cmd_if.cmd_data0   = 64'h11 * 64'(i + 1);
      tick();
      check("data_a_wren", mem_a_wren, 1);
      check("data_a_addr", mem_a_waddr, 64'(i));
      check("data_a_data", mem_a_wdata, 64'h11 * 64'(i + 1));
      $display("[TB] DATA_A write addr=%0d data=%0h", mem_a_waddr, mem_a_wdata);
    end
    cmd_if.cmd_valid = 1'b0;
    tick();
    check("data_a_idle", mem_a_wren, 0);
    beat(8'd3, 64'd2);
    check("size_b_2", size_b, 2);
    for (int i = 0; i < 2; i++) begin
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_command = 8'd5;
      cmd_if.cmd_data0   = 64'hB0 + 64'(i);
      tick();
      check("data_b_wren", mem_b_wren, 1);
      check("data_b_addr", mem_b_waddr, 64'(i));
      check("data_b_data", mem_b_wdata, 64'hB0 + 64'(i));
      $display("[TB] DATA_B write addr=%0d data=%0h", mem_b_waddr, mem_b_wdata);
    end
    cmd_if.cmd_valid = 1'b0;
    tick();
    check("data_b_idle", mem_b_wren, 0);

    // Multiplication: KARATSUBA at T, core_done at T+10
    beat(8'd7, 64'h100);
    check("out_addr", out_addr, 64'h100);
    beat(8'd6, 64'd0);
    check("kara_start_t1", core_start, 1);
    check("kara_busy_t1", busy, 1);
    check("kara_ready_t1", cmd_if.cmd_ready, 0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      check("kara_start_low", core_start, 0);
      check("kara_busy_run", busy, 1);
      check("kara_done_low", done, 0);
      if (k == 10) core_done = 1'b1;
    end
    tick();
    core_done = 1'b0;
    check("kara_done_t11", done, 1);
    check("kara_busy_t11", busy, 1);
    check("kara_ready_t11", cmd_if.cmd_ready, 0);
    tick();
    check("kara_done_t12", done, 0);
    check("kara_ready_t12", cmd_if.cmd_ready, 1);
    check("kara_busy_t12", busy, 0);
    check("kara_out_addr_kept", out_addr, 64'h100);
    check("kara_sizes_kept", {size_a, size_b}, {32'd4, 32'd2});
    $display("[TB] KARATSUBA complete out_addr=%0h", out_addr);
    beat(8'd4, 64'h99);
    check("ptr_a_rewound", mem_a_waddr, 0);
    check("ptr_a_rewound_wren", mem_a_wren, 1);

    // Zero size B rejected, then RESET
    beat(8'd3, 64'd0);
    beat(8'd6, 64'd0);
    check("size0_no_start", core_start, 0);
    check("size0_err", err_size, 1);
    check("size0_idle", busy, 0);
    tick();
    check("size0_no_start2", core_start, 0);
    beat(8'd1, 64'd0);
    check("reset_clears_err", err_size, 0);
    check("reset_soft_pulse", core_soft_reset, 1);
    check("reset_size_a", size_a, 0);
    tick();
    check("reset_soft_once", core_soft_reset, 0);
    $display("[TB] size error and RESET checked");

    // Overflow: fill to 0x27FF, then two more DATA_A
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_command = 8'd4;
    for (int i = 0; i < 32'h27FF; i++) begin
      cmd_if.cmd_data0 = 64'(i);
      tick();
    end
    cmd_if.cmd_data0 = 64'hABCD;
    tick();
    check("ovf_last_wren", mem_a_wren, 1);
    check("ovf_last_addr", mem_a_waddr, 64'h27FF);
    check("ovf_last_data", mem_a_wdata, 64'hABCD);
    check("ovf_no_err_yet", err_overflow, 0);
    cmd_if.cmd_data0 = 64'hDEAD;
    tick();
    check("ovf_drop_wren", mem_a_wren, 0);
    check("ovf_err", err_overflow, 1);
    tick();
    check("ovf_saturated", mem_a_wren, 0);
    cmd_if.cmd_valid = 1'b0;
    $display("[TB] overflow checked addr=%0h", mem_a_waddr);

    // Unknown opcodes
    beat(8'd1, 64'd0);
    beat(8'h55, 64'h1234);
    check("op55_err", err_opcode, 1);
    check("op55_no_write", {mem_a_wren, mem_b_wren, core_start}, 0);
    beat(8'd1, 64'd0);
    check("op_cleared", err_opcode, 0);
    beat(8'd0, 64'd0);
    check("op0_err", err_opcode, 1);

    // DATA_A held during RUN is consumed exactly once, at DONE+1
    beat(8'd2, 64'd1);
    beat(8'd3, 64'd1);
    beat(8'd6, 64'd0);
    check("held_start", core_start, 1);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_command = 8'd4;
    cmd_if.cmd_data0   = 64'h77;
    tick();
    check("held_run_no_write", mem_a_wren, 0);
    check("held_run_not_ready", cmd_if.cmd_ready, 0);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("held_done", done, 1);
    check("held_done_no_write", mem_a_wren, 0);
    tick();
    check("held_done1_ready", cmd_if.cmd_ready, 1);
    check("held_done1_no_write", mem_a_wren, 0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("held_write", mem_a_wren, 1);
    check("held_write_addr", mem_a_waddr, 0);
    check("held_write_data", mem_a_wdata, 64'h77);
    tick();
    check("held_write_once", mem_a_wren, 0);
    $display("[TB] held beat accepted once data=%0h", mem_a_wdata);

    // rst mid-RUN followed by a late core_done
    beat(8'd7, 64'h200);
    beat(8'd6, 64'd0);
    tick();
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_ready", cmd_if.cmd_ready, 1);
    check("midrun_busy0", busy, 0);
    check("midrun_regs", {size_a, size_b}, 0);
    check("midrun_out_addr", out_addr, 0);
    check("midrun_errs", {err_overflow, err_size, err_opcode}, 0);
    check("midrun_wdata", mem_a_wdata, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("midrun_late_done", done, 0);
    check("midrun_late_busy", busy, 0);
    tick();
    check("midrun_late_done2", done, 0);
    $display("[TB] reset mid-RUN checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
